// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle for the two dmem_arbiter requesters.
interface dmem_arbiter_if;
   logic        req0_valid, req0_ready, req0_we;
   logic [31:0] req0_addr, req0_wdata;
   logic [2:0]  req0_size;
   logic        rsp0_valid, rsp0_err;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [31:0] req1_addr, req1_wdata;
   logic [2:0]  req1_size;
   logic        rsp1_valid, rsp1_err;
   logic [31:0] rsp1_rdata;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata, req0_size,
             req1_valid, req1_we, req1_addr, req1_wdata, req1_size,
      output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
             req1_ready, rsp1_valid, rsp1_err, rsp1_rdata
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata, req0_size,
             req1_valid, req1_we, req1_addr, req1_wdata, req1_size,
      input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
             req1_ready, rsp1_valid, rsp1_err, rsp1_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter for two requesters in front of a 1R1W word memory,
// with byte/half extraction on loads and read-modify-write for sub-word stores.
module dmem_arbiter #(
   parameter int   MEM_DEPTH = 4,
   parameter logic RR_INIT   = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus,
   output logic [31:0]   mem_rd_addr,
   output logic [31:0]   mem_wr_addr,
   output logic [31:0]   mem_wr_din,
   output logic          mem_we,
   input  logic [31:0]   mem_rd_dout
);
   typedef enum logic [1:0] {IDLE, READ, RESP, WRITE} state_t;

   state_t      state_q;
   logic        rr_q, id_q, we_q, err_q;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  size_q;

   logic        both, gnt, acc, sel_we, sel_err, rsp_fire;
   logic [31:0] sel_addr, sel_wdata;
   logic [2:0]  sel_size;
   logic [31:0] word_addr, shifted, ld_data, lane_mask, merged, rdata;
   logic [4:0]  sh;

   always_comb begin
      both      = bus.req0_valid & bus.req1_valid;
      gnt       = both ? rr_q : bus.req1_valid;
      acc       = ~rst & (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
      sel_we    = gnt ? bus.req1_we    : bus.req0_we;
      sel_addr  = gnt ? bus.req1_addr  : bus.req0_addr;
      sel_wdata = gnt ? bus.req1_wdata : bus.req0_wdata;
      sel_size  = gnt ? bus.req1_size  : bus.req0_size;
      sel_err   = (sel_size[1:0] == 2'b11)
                | ((sel_size[1:0] == 2'b01) & sel_addr[0])
                | ((sel_size[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00))
                | ({2'b00, sel_addr[31:2]} >= 32'(MEM_DEPTH));
   end

   assign bus.req0_ready = acc & ~gnt;
   assign bus.req1_ready = acc & gnt;

   // Errors skip memory entirely; word stores need no read phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= RR_INIT;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         size_q  <= 3'b000;
      end else begin
         case (state_q)
            IDLE: if (acc) begin
               id_q    <= gnt;
               we_q    <= sel_we;
               err_q   <= sel_err;
               addr_q  <= sel_addr;
               wdata_q <= sel_wdata;
               size_q  <= sel_size;
               if (both) rr_q <= ~gnt;
               state_q <= sel_err ? RESP : (sel_we & (sel_size[1:0] == 2'b10)) ? WRITE : READ;
            end
            READ:    state_q <= we_q ? WRITE : RESP;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      word_addr   = {addr_q[31:2], 2'b00};
      sh          = {addr_q[1:0], 3'b000};
      shifted     = mem_rd_dout >> sh;
      ld_data     = (size_q[1:0] == 2'b00) ? {{24{~size_q[2] & shifted[7]}}, shifted[7:0]}
                  : (size_q[1:0] == 2'b01) ? {{16{~size_q[2] & shifted[15]}}, shifted[15:0]}
                  : shifted;
      lane_mask   = ((size_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      merged      = (mem_rd_dout & ~lane_mask) | ((wdata_q << sh) & lane_mask);
      mem_we      = ~rst & (state_q == WRITE);
      mem_rd_addr = (~rst & (state_q == READ)) ? word_addr : 32'h0;
      mem_wr_addr = mem_we ? word_addr : 32'h0;
      mem_wr_din  = mem_we ? ((size_q[1:0] == 2'b10) ? wdata_q : merged) : 32'h0;
      rsp_fire    = ~rst & ((state_q == RESP) | (state_q == WRITE));
      rdata       = (~rst & (state_q == RESP) & ~err_q) ? ld_data : 32'h0;
   end

   assign bus.rsp0_valid = rsp_fire & ~id_q;
   assign bus.rsp1_valid = rsp_fire & id_q;
   assign bus.rsp0_err   = bus.rsp0_valid & err_q;
   assign bus.rsp1_err   = bus.rsp1_valid & err_q;
   assign bus.rsp0_rdata = id_q ? 32'h0 : rdata;
   assign bus.rsp1_rdata = id_q ? rdata : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: byte-level memory model plus transaction scheduler checked every cycle,
// directed literal scenarios followed by randomized two-requester traffic with random resets.
module tb_dmem_arbiter;
   localparam int D = 4;

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_din;
   logic [31:0] mem_rd_dout = 32'h0;
   logic        mem_we;
   logic [31:0] mem [D] = '{default: 32'h0};
   logic [7:0]  ref_b [4*D] = '{default: 8'h0};
   int          vectors = 0, miscompares = 0, we_cnt = 0;
   logic [31:0] last_wd = 32'h0;

   dmem_arbiter_if bus();

   dmem_arbiter #(.MEM_DEPTH(D), .RR_INIT(1'b0)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
      .mem_we(mem_we), .mem_rd_dout(mem_rd_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_wr_addr[3:2]] <= mem_wr_din;
      mem_rd_dout <= mem[mem_rd_addr[3:2]];
   end

   always @(negedge clk) if (mem_we === 1'b1) begin
      we_cnt++;
      last_wd = mem_wr_din;
   end

   function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", n, act, exp, $time);
      end
   endfunction

   function automatic logic bad(input logic [31:0] a, input logic [2:0] s);
      int n = 1 << s[1:0];
      return s[1:0] == 2'b11 || a % n != 0 || a / 4 >= D;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] s);
      int n = 1 << s[1:0];
      logic [31:0] v = 32'h0;
      for (int i = 0; i < n; i++) v |= 32'(ref_b[a + i]) << (8 * i);
      if (!s[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
      return v;
   endfunction

   function automatic logic [31:0] stored_word(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      int n = 1 << s[1:0];
      logic [31:0] base = a - a % 4;
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = ref_b[base + i];
      for (int i = 0; i < n; i++) b[a % 4 + i] = 8'(d >> (8 * i));
      return {b[3], b[2], b[1], b[0]};
   endfunction

   // Transaction-level model: phase counts cycles since accept, last is the response cycle.
   int          ph = 0, last = 0;
   logic        m_rr = 1'b0;
   logic        t_id, t_we, t_err;
   logic [31:0] t_addr, t_wd, t_rdata, t_word;
   logic [2:0]  t_size;

   always @(negedge clk) begin : model
      logic [1:0]  e_rdy, e_rv, e_er;
      logic [31:0] e_rd, e_ra, e_wa, e_wd, base;
      logic        e_we, g, any;
      e_rdy = 0; e_rv = 0; e_er = 0; e_rd = 0; e_ra = 0; e_wa = 0; e_wd = 0; e_we = 0;
      any = bus.req0_valid | bus.req1_valid;
      g = (bus.req0_valid & bus.req1_valid) ? m_rr : bus.req1_valid;
      base = t_addr - t_addr % 4;
      if (!rst && ph == 0 && any) e_rdy[g] = 1'b1;
      else if (!rst && ph != 0) begin
         if (t_err) begin e_rv[t_id] = 1'b1; e_er[t_id] = 1'b1; end
         else if (ph == 1 && last == 2) e_ra = base;
         else if (!t_we) begin e_rv[t_id] = 1'b1; e_rd = t_rdata; end
         else begin e_rv[t_id] = 1'b1; e_we = 1'b1; e_wa = base; e_wd = t_word; end
      end
      chk("ready", {bus.req1_ready, bus.req0_ready}, e_rdy);
      chk("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, e_rv);
      chk("rsp_err", {bus.rsp1_err, bus.rsp0_err}, e_er);
      chk("rsp0_rdata", bus.rsp0_rdata, t_id ? 32'h0 : e_rd);
      chk("rsp1_rdata", bus.rsp1_rdata, t_id ? e_rd : 32'h0);
      chk("mem_we", mem_we, e_we);
      chk("mem_rd_addr", mem_rd_addr, e_ra);
      chk("mem_wr_addr", mem_wr_addr, e_wa);
      chk("mem_wr_din", mem_wr_din, e_wd);
      if (rst) begin
         ph = 0;
         m_rr = 1'b0;
      end else if (ph == 0 && any) begin
         t_id   = g;
         t_we   = g ? bus.req1_we    : bus.req0_we;
         t_addr = g ? bus.req1_addr  : bus.req0_addr;
         t_wd   = g ? bus.req1_wdata : bus.req0_wdata;
         t_size = g ? bus.req1_size  : bus.req0_size;
         t_err  = bad(t_addr, t_size);
         last   = (t_err || (t_we && t_size[1:0] == 2'b10)) ? 1 : 2;
         t_rdata = (t_err || t_we) ? 32'h0 : load_val(t_addr, t_size);
         t_word  = (t_err || !t_we) ? 32'h0 : stored_word(t_addr, t_size, t_wd);
         if (bus.req0_valid && bus.req1_valid) m_rr = ~g;
         ph = 1;
      end else if (ph != 0) begin
         if (ph == last && t_we && !t_err)
            for (int i = 0; i < 4; i++) ref_b[base + i] = t_word[8*i +: 8];
         ph = (ph == last) ? 0 : ph + 1;
      end
   end

   task automatic drive(input int id, input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] s);
      if (id == 0) begin
         bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_size = s;
      end else begin
         bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_size = s;
      end
   endtask

   function automatic logic rdy(input int id);
      return id != 0 ? bus.req1_ready : bus.req0_ready;
   endfunction

   function automatic logic rv(input int id);
      return id != 0 ? bus.rsp1_valid : bus.rsp0_valid;
   endfunction

   task automatic xact(input int id, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s, output logic [31:0] rd, output logic er,
                       output int lat, output int wt);
      drive(id, 1'b1, we, a, d, s);
      wt = 0;
      @(negedge clk);
      while (!rdy(id) && wt < 20) begin @(negedge clk); wt++; end
      chk("accept", rdy(id), 1'b1);
      @(posedge clk); #1;
      drive(id, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      lat = 1;
      @(negedge clk);
      while (!rv(id) && lat < 10) begin @(negedge clk); lat++; end
      chk("rsp_seen", rv(id), 1'b1);
      rd = id != 0 ? bus.rsp1_rdata : bus.rsp0_rdata;
      er = id != 0 ? bus.rsp1_err : bus.rsp0_err;
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a;
      logic        er, f0, f1;
      int          lat, wt, w0;
      bit          pend [2];
      int          gid[$], gcyc[$];
      int          e_id [4] = '{0, 1, 0, 1};
      logic        e_we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] e_a  [4] = '{32'h3, 32'h2, 32'h0, 32'(4 * D)};
      logic [2:0]  e_s  [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
      drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      repeat (2) @(negedge clk);
      chk("ready_in_reset", {bus.req1_ready, bus.req0_ready}, 2'b00);
      chk("we_in_reset", mem_we, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      rst = 1'b0;
      @(posedge clk); #1;
      w0 = we_cnt;
      xact(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 3'b010, rd, er, lat, wt);
      chk("st_word_lat", lat, 1);
      chk("st_word_din", last_wd, 32'hDEAD_BEEF);
      xact(0, 1'b0, 32'h4, 32'h0, 3'b010, rd, er, lat, wt);
      chk("ld_word", rd, 32'hDEAD_BEEF);
      chk("ld_word_lat", lat, 2);
      chk("we_once", we_cnt - w0, 1);
      xact(1, 1'b1, 32'h6, 32'h55, 3'b000, rd, er, lat, wt);
      chk("st_byte_din", last_wd, 32'hDE55_BEEF);
      chk("st_byte_lat", lat, 2);
      xact(0, 1'b0, 32'h6, 32'h0, 3'b000, rd, er, lat, wt);
      chk("ld_byte6", rd, 32'h0000_0055);
      xact(0, 1'b1, 32'h0, 32'h0000_F080, 3'b010, rd, er, lat, wt);
      xact(0, 1'b0, 32'h0, 32'h0, 3'b001, rd, er, lat, wt);
      chk("ld_half_s", rd, 32'hFFFF_F080);
      xact(0, 1'b0, 32'h0, 32'h0, 3'b101, rd, er, lat, wt);
      chk("ld_half_u", rd, 32'h0000_F080);
      xact(0, 1'b0, 32'h1, 32'h0, 3'b000, rd, er, lat, wt);
      chk("ld_byte1_s", rd, 32'hFFFF_FFF0);
      w0 = we_cnt;
      for (int k = 0; k < 4; k++) begin
         xact(e_id[k], e_we[k], e_a[k], 32'hCAFE_F00D, e_s[k], rd, er, lat, wt);
         chk($sformatf("err%0d_flag", k), er, 1'b1);
         chk($sformatf("err%0d_rdata", k), rd, 32'h0);
         chk($sformatf("err%0d_lat", k), lat, 1);
      end
      chk("err_no_we", we_cnt - w0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
      drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (bus.req0_ready) begin gid.push_back(0); gcyc.push_back(c); end
         if (bus.req1_ready) begin gid.push_back(1); gcyc.push_back(c); end
         @(posedge clk); #1;
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      chk("grant_count", gid.size(), 6);
      for (int k = 0; k < 4 && k + 1 < gid.size(); k++) begin
         chk($sformatf("grant%0d", k), gid[k], k % 2);
         chk($sformatf("accept_gap%0d", k), gcyc[k+1] - gcyc[k], 3);
      end
      repeat (4) @(posedge clk);
      #1;
      xact(0, 1'b1, 32'h8, 32'h1234_5678, 3'b010, rd, er, lat, wt);
      w0 = we_cnt;
      drive(0, 1'b1, 1'b1, 32'h8, 32'hAA, 3'b000);
      @(negedge clk);
      chk("abort_accept", bus.req0_ready, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_we", mem_we, 1'b0);
      chk("abort_rsp", bus.rsp0_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      xact(0, 1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat, wt);
      chk("abort_idle", wt, 0);
      chk("abort_readback", rd, 32'h1234_5678);
      chk("abort_no_we", we_cnt - w0, 0);
      pend[0] = 0;
      pend[1] = 0;
      for (int c = 0; c < 800; c++) begin
         for (int id = 0; id < 2; id++) if (!pend[id] && $urandom_range(0, 2) == 0) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 4 * D + 3);
            drive(id, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
            pend[id] = 1;
         end
         rst = ($urandom_range(0, 79) == 0);
         @(negedge clk);
         f0 = pend[0] && bus.req0_ready;
         f1 = pend[1] && bus.req1_ready;
         @(posedge clk); #1;
         if (f0) begin drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000); pend[0] = 0; end
         if (f1) begin drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000); pend[1] = 0; end
      end
      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      repeat (5) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
